// File: rtl/cntry_vehicle_detector.sv
// Country-road vehicle detector: sensor synchronizer/debounce, vehicle queue and car-present request X.
// Optional stuck-sensor monitor (forces X high while the loop reads stuck) is enabled by SENSOR_STUCK_EN.
module cntry_vehicle_detector #(
    parameter int DEB_CYC   = 4,
    parameter int QW        = 4,
    parameter int SERVE_CYC = 2,
    parameter int MIN_GAP   = 8,
    parameter int STUCK_CYC = 64
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          sensor_raw,
    input  logic [1:0]    cntry,
    output logic          X,
    output logic [QW-1:0] queue_cnt,
    output logic          overflow,
    output logic          sensor_fault
);
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int TW = $clog2(SERVE_CYC + 1);
    localparam int GW = $clog2(MIN_GAP + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(SERVE_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(MIN_GAP - 1);
    localparam logic [1:0]    GREEN    = 2'd2;

    typedef enum logic [1:0] {IDLE, REQUEST, SERVE, GAP} state_t;

    state_t        state;
    logic          sync_p0;
    logic          s_sync;
    logic          s_db;
    logic          s_db_p;
    logic [DW-1:0] deb_cnt;
    logic          arrive;
    logic [TW-1:0] tmr;
    logic [GW-1:0] gap_cnt;
    logic          x_q;
    logic          green;
    logic          depart;
    logic          fault_next;
    logic [QW:0]   q_step;

    // Returns {lost_arrival, next_count}; an arrival at full scale is dropped.
    function automatic logic [QW:0] queue_step(input logic [QW-1:0] q,
                                               input logic          arr,
                                               input logic          dep);
        logic [QW:0] r;
        r = {1'b0, q};
        if (arr && !dep) begin
            if (&q) r[QW] = 1'b1;
            else    r = {1'b0, q + QW'(1)};
        end else if (dep && !arr) begin
            r = {1'b0, q - QW'(1)};
        end
        return r;
    endfunction

    assign green  = (cntry == GREEN);
    assign depart = green && (tmr == TMR_LAST) && (queue_cnt != '0);
    assign q_step = queue_step(queue_cnt, arrive, depart);
    assign X      = x_q;

    // Synchronizer and debounce stage
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            sync_p0 <= 1'b0;
            s_sync  <= 1'b0;
            s_db    <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync_p0 <= sensor_raw;
            s_sync  <= sync_p0;
            if (s_sync == s_db) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                s_db    <= ~s_db;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    // Arrival edge detect, serve timer and queue stage
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            s_db_p    <= 1'b0;
            arrive    <= 1'b0;
            tmr       <= '0;
            queue_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            s_db_p    <= s_db;
            arrive    <= s_db & ~s_db_p;
            if (!green || tmr == TMR_LAST) tmr <= '0;
            else                           tmr <= tmr + TW'(1);
            queue_cnt <= q_step[QW-1:0];
            if (q_step[QW]) overflow <= 1'b1;
        end
    end

    // Request FSM stage; X leaves this block already registered
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state   <= IDLE;
            gap_cnt <= '0;
            x_q     <= 1'b0;
        end else begin
            x_q     <= fault_next;
            gap_cnt <= '0;
            case (state)
                IDLE: begin
                    if (queue_cnt != '0) begin
                        state <= REQUEST;
                        x_q   <= 1'b1;
                    end
                end
                REQUEST: begin
                    x_q <= 1'b1;
                    if (green) state <= SERVE;
                end
                SERVE: begin
                    if (queue_cnt == '0) begin
                        state <= GAP;
                    end else begin
                        x_q <= 1'b1;
                        if (!green) state <= REQUEST;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) state <= IDLE;
                    else                     gap_cnt <= gap_cnt + GW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SENSOR_STUCK_EN
    localparam int SW = $clog2(STUCK_CYC + 1);
    localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_CYC - 1);
    localparam logic [SW-1:0] STUCK_MAX  = SW'(STUCK_CYC);

    logic [SW-1:0] stuck_cnt;
    logic          fault_q;

    // The fault holds for as long as the debounced sensor stays high
    assign fault_next   = s_db && (fault_q || stuck_cnt == STUCK_LAST);
    assign sensor_fault = fault_q;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            stuck_cnt <= '0;
            fault_q   <= 1'b0;
        end else begin
            fault_q <= fault_next;
            if (!s_db)                       stuck_cnt <= '0;
            else if (stuck_cnt != STUCK_MAX) stuck_cnt <= stuck_cnt + SW'(1);
        end
    end
`else
    assign fault_next   = 1'b0;
    assign sensor_fault = 1'b0;
`endif

endmodule

// File: tb/tb_cntry_vehicle_detector.sv
// Directed bench for cntry_vehicle_detector: per-cycle vector table plus hand-timed service,
// simultaneous-event, saturation, mid-operation reset and stuck-sensor sequences.
module tb_cntry_vehicle_detector;
    localparam logic [1:0] RED = 2'd0, YELLOW = 2'd1, GREEN = 2'd2, DARK = 2'd3;

    logic       clock = 1'b0;
    logic       clear = 1'b0;
    logic       sensor_raw = 1'b0;
    logic [1:0] cntry = RED;
    logic       X;
    logic [3:0] queue_cnt;
    logic       overflow;
    logic       sensor_fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       raw;
        logic [1:0] cn;
        logic       x;
        logic [3:0] q;
        logic       ovf;
    } vec_t;
    vec_t vecs[$];

    cntry_vehicle_detector dut (
        .clock        (clock),
        .clear        (clear),
        .sensor_raw   (sensor_raw),
        .cntry        (cntry),
        .X            (X),
        .queue_cnt    (queue_cnt),
        .overflow     (overflow),
        .sensor_fault (sensor_fault)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic r, input logic [1:0] c, input logic x, input int q, input logic o);
        vec_t v;
        v.raw = r;
        v.cn  = c;
        v.x   = x;
        v.q   = q[3:0];
        v.ovf = o;
        vecs.push_back(v);
    endtask

    // One clean vehicle: 6 cycles high then 6 low; the debounced sensor is back at 0 on return.
    task automatic car();
        sensor_raw = 1'b1;
        repeat (6) step();
        sensor_raw = 1'b0;
        repeat (6) step();
    endtask

    initial begin
        // Row i is driven after edge i; expectations are the outputs after edge i+1.
        for (int i = 0; i < 12; i++) add(i < 3, RED, 1'b0, 0, 1'b0);
        for (int i = 0; i < 12; i++) add(i < 6, DARK, i >= 8, (i >= 7) ? 1 : 0, 1'b0);

        // Reset held while the sensor toggles
        clear = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sensor_raw = ~sensor_raw;
            #7;
        end
        check("reset X", X, 0);
        check("reset queue", queue_cnt, 0);
        check("reset overflow", overflow, 0);
        check("reset fault", sensor_fault, 0);
        @(posedge clock);
        #1;
        clear = 1'b1;
        repeat (5) step();
        check("post-reset X", X, 0);
        check("post-reset queue", queue_cnt, 0);

        // Glitch rejection and arrival latency from the table
        for (int i = 0; i < vecs.size(); i++) begin
            sensor_raw = vecs[i].raw;
            cntry      = vecs[i].cn;
            step();
            check($sformatf("vec%0d X", i), X, vecs[i].x);
            check($sformatf("vec%0d queue", i), queue_cnt, vecs[i].q);
            check($sformatf("vec%0d overflow", i), overflow, vecs[i].ovf);
        end

        // Service with a yellow interruption, then the re-request gap
        cntry = RED;
        car();
        car();
        check("svc queued", queue_cnt, 3);
        check("svc X queued", X, 1);
        cntry = GREEN;
        step();
        check("svc G1 queue", queue_cnt, 3);
        step();
        check("svc G2 queue", queue_cnt, 2);
        cntry = YELLOW;
        repeat (3) step();
        check("svc yellow queue", queue_cnt, 2);
        check("svc yellow X", X, 1);
        cntry = GREEN;
        step();
        check("svc H1 queue", queue_cnt, 2);
        step();
        check("svc H2 queue", queue_cnt, 1);
        step();
        step();
        check("svc H4 queue", queue_cnt, 0);
        check("svc H4 X", X, 1);
        sensor_raw = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) cntry = RED;
            if (k == 6) sensor_raw = 1'b0;
            if (k <= 9) check($sformatf("gap X k%0d", k), X, 0);
            if (k == 7) check("gap queue before arrival", queue_cnt, 0);
            if (k == 8) check("gap queue arrival", queue_cnt, 1);
            if (k == 10) check("gap X re-raised", X, 1);
        end

        // Arrival coinciding with a departure
        car();
        check("sim queue before", queue_cnt, 2);
        sensor_raw = 1'b1;
        repeat (6) step();
        sensor_raw = 1'b0;
        cntry = GREEN;
        step();
        check("sim e7 queue", queue_cnt, 2);
        step();
        check("sim e8 queue", queue_cnt, 2);
        step();
        step();
        check("sim e10 queue", queue_cnt, 1);
        step();
        step();
        check("sim e12 queue", queue_cnt, 0);
        cntry = RED;

        // Saturation and sticky overflow
        repeat (15) car();
        check("sat 15 queue", queue_cnt, 15);
        check("sat 15 overflow", overflow, 0);
        car();
        check("sat 16 queue", queue_cnt, 15);
        check("sat 16 overflow", overflow, 1);
        cntry = GREEN;
        repeat (29) step();
        check("drain e29 queue", queue_cnt, 1);
        step();
        check("drain e30 queue", queue_cnt, 0);
        check("drain overflow sticky", overflow, 1);

        // Asynchronous reset while serving
        cntry = RED;
        repeat (5) car();
        check("mid queue", queue_cnt, 5);
        cntry = GREEN;
        step();
        check("mid serve queue", queue_cnt, 5);
        check("mid serve X", X, 1);
        #2;
        clear = 1'b0;
        #1;
        check("mid reset X", X, 0);
        check("mid reset queue", queue_cnt, 0);
        check("mid reset overflow", overflow, 0);
        @(posedge clock);
        #1;
        clear = 1'b1;
        cntry = RED;
        repeat (3) step();
        check("mid after X", X, 0);
        check("mid after queue", queue_cnt, 0);

        // Sensor held high for 80 cycles with the country road green
        cntry = GREEN;
        sensor_raw = 1'b1;
        repeat (80) step();
        check("stuck queue", queue_cnt, 0);
`ifdef SENSOR_STUCK_EN
        check("stuck fault", sensor_fault, 1);
        check("stuck X forced", X, 1);
        sensor_raw = 1'b0;
        repeat (10) step();
        check("stuck fault cleared", sensor_fault, 0);
        check("stuck X released", X, 0);
`else
        check("stuck fault absent", sensor_fault, 0);
        check("stuck X", X, 0);
        sensor_raw = 1'b0;
        repeat (10) step();
        check("stuck fault still absent", sensor_fault, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cntry_vehicle_detector.md
Name: cntry_vehicle_detector

Overview:
- Upstream stage of the highway/country signal controller. Conditions the raw country-road loop sensor, counts queued vehicles, and generates the controller's car-present request X.
- Watches the controller's country-light output to retire queued cars while the country road is green.
- Holds X until the queue drains, then enforces a minimum re-request gap.

Parameters:
- DEB_CYC, 4: consecutive stable cycles required before the debounced sensor changes (>=1).
- QW, 4: queue counter width; the counter saturates at 2^QW-1.
- SERVE_CYC, 2: country-green cycles per departing vehicle (>=1).
- MIN_GAP, 8: cycles X is held low after a service phase ends (>=1).
- STUCK_CYC, 64: used only when SENSOR_STUCK_EN is defined.

Ports:
- clock, input, 1: single clock, rising edge.
- clear, input, 1: asynchronous, active-low reset.
- sensor_raw, input, 1: raw loop detector, asynchronous to clock.
- cntry, input, 2: country light state from the controller (0 RED, 1 YELLOW, 2 GREEN, 3 treated as RED).
- X, output, 1: car-present request to the controller (registered).
- queue_cnt, output, QW: vehicles currently queued.
- overflow, output, 1: sticky flag, set when an arrival is lost at saturation.
- sensor_fault, output, 1: stuck-sensor flag; constant 0 unless SENSOR_STUCK_EN is defined.

Behaviour:
- Reset (clear=0, asynchronous): all flops 0. State IDLE, X=0, queue_cnt=0, overflow=0, sensor_fault=0, debounced sensor=0. Reset mid-service discards the queue.
- Synchronizer: 2-flop chain on sensor_raw, giving s_sync.
- Debounce: a counter increments while s_sync != s_db and is cleared whenever they are equal. s_db toggles, and the counter clears, on the edge where the counter reaches DEB_CYC-1.
- Arrival: one-cycle registered pulse on each 0->1 edge of s_db. A 1->0 edge produces nothing.
- Departure:
  - A serve timer runs only while cntry==GREEN and is cleared otherwise.
  - When the timer equals SERVE_CYC-1 and queue_cnt>0, a depart pulse fires and the timer wraps to 0.
- Queue update on each edge:
  - arrive only: +1. At 2^QW-1 the count holds and overflow is set.
  - depart only: -1. The count never underflows, because depart requires queue_cnt>0.
  - arrive and depart together: unchanged, and overflow is not set.
- FSM (X=1 in REQUEST and SERVE, X=0 otherwise):
  - IDLE: queue_cnt!=0 -> REQUEST.
  - REQUEST: cntry==GREEN -> SERVE.
  - SERVE:
    - queue_cnt==0 -> GAP.
    - cntry!=GREEN while queue_cnt>0 -> REQUEST, with X kept at 1.
  - GAP: a gap counter counts MIN_GAP cycles, then -> IDLE. Arrivals during GAP still enqueue, but the request waits for IDLE.
- Latency, raw rise to X rise: sensor_raw high and stable, first sampled at edge 0.
  - s_sync=1 at edge 2.
  - s_db=1 at edge 2+DEB_CYC.
  - arrive at edge 3+DEB_CYC.
  - queue_cnt=1 at edge 4+DEB_CYC.
  - X=1 at edge 5+DEB_CYC, which is edge 9 at the default parameters.
- Glitches shorter than DEB_CYC synchronized cycles never change s_db.

Optional Feature:
- Macro SENSOR_STUCK_EN.
- Defined:
  - A stuck counter increments while s_db==1 and clears when s_db==0. sensor_fault sets when the count reaches STUCK_CYC, and clears on the edge after s_db returns to 0.
  - While sensor_fault=1, X is forced to 1 in every state. This is fail-safe: the country road is always eventually served.
  - The queue logic is unaffected.
- Undefined: no stuck counter is built, sensor_fault is tied to 0, and X comes from the FSM alone.

Test Plan:
- Reset: hold clear=0, toggle sensor_raw -> X=0, queue_cnt=0, overflow=0. Release clear -> all outputs stay 0 until a valid arrival.
- Glitch rejection: 3-cycle sensor_raw pulse (defaults) -> s_db, queue_cnt and X are unchanged. 6-cycle pulse -> queue_cnt=1 at edge 8, X=1 at edge 9.
- Service: 3 cars queued, then cntry=GREEN -> queue_cnt goes 3->2->1->0 every 2 cycles. X drops 1 cycle after 0, stays 0 for 8 cycles, and a new arrival then re-raises X.
- Simultaneous events: arrival edge coincides with a depart pulse at queue_cnt=2 -> queue_cnt stays 2.
- Saturation: 16 arrivals with cntry=RED -> queue_cnt=15, overflow=1. Overflow stays 1 after the queue drains, until the next clear.
- Mid-operation reset and stuck sensor: clear pulsed low in SERVE with queue_cnt=5 -> immediately X=0, queue_cnt=0. With SENSOR_STUCK_EN defined, hold sensor_raw high for 80 cycles -> sensor_fault=1, and X=1 even with the queue drained.
